// File: rtl/l1_cache_assoc.sv
// N-way set-associative write-back, write-allocate L1 data cache.
// True-LRU replacement, ready/valid CPU side, acked word-serial memory side.
module l1_cache_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cpu_read_en,
  input  logic                  i_cpu_write_en,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_write_data,
  output logic                  o_cpu_ready,
  output logic [DATA_WIDTH-1:0] o_cpu_read_data,
  output logic                  o_cpu_data_valid,
  output logic                  o_mem_read_en,
  output logic                  o_mem_write_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data,
  input  logic                  i_mem_ack
);

  localparam int BOFF_W = $clog2(DATA_WIDTH / 8);
  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_WIDTH - BOFF_W - WOFF_W - IDX_W;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [WOFF_W-1:0] LAST = WOFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITE_BACK,
    S_FILL,
    S_RESPOND
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_q;
  logic [WAY_W-1:0]      way_q;
  logic [WOFF_W-1:0]     cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  valid_q;

  logic [TAG_W-1:0]      tag_q   [NUM_WAYS][NUM_SETS];
  logic [NUM_WAYS-1:0]   vld_q   [NUM_SETS];
  logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
  logic [WAY_W-1:0]      age_q   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data_q  [NUM_WAYS][NUM_SETS][LINE_WORDS];

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WOFF_W-1:0] req_word;

  assign req_tag  = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx  = addr_q[BOFF_W+WOFF_W +: IDX_W];
  assign req_word = addr_q[BOFF_W +: WOFF_W];

  logic unused_ok;
  assign unused_ok = ^addr_q[BOFF_W-1:0];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] old_way;
  logic [WAY_W-1:0] max_age;
  logic [WAY_W-1:0] vic_way;

  // Victim: lowest invalid way, else first way holding the maximum age
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    old_way   = '0;
    max_age   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (vld_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!vld_q[req_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_q[req_idx][w] > max_age) begin
        max_age = age_q[req_idx][w];
        old_way = WAY_W'(w);
      end
    end
    vic_way = inv_found ? inv_way : old_way;
  end

  always_comb begin
    state_d          = state_q;
    o_cpu_ready      = 1'b0;
    o_mem_read_en    = 1'b0;
    o_mem_write_en   = 1'b0;
    o_mem_addr       = '0;
    o_mem_write_data = '0;
    unique case (state_q)
      S_IDLE: begin
        o_cpu_ready = 1'b1;
        if (i_cpu_read_en || i_cpu_write_en) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit)
          state_d = S_RESPOND;
        else if (vld_q[req_idx][vic_way] && dirty_q[req_idx][vic_way])
          state_d = S_WRITE_BACK;
        else
          state_d = S_FILL;
      end
      S_WRITE_BACK: begin
        o_mem_write_en   = 1'b1;
        o_mem_addr       = {tag_q[way_q][req_idx], req_idx, cnt_q,
                            {BOFF_W{1'b0}}};
        o_mem_write_data = data_q[way_q][req_idx][cnt_q];
        if (i_mem_ack && cnt_q == LAST) state_d = S_FILL;
      end
      S_FILL: begin
        o_mem_read_en = 1'b1;
        o_mem_addr    = {req_tag, req_idx, cnt_q, {BOFF_W{1'b0}}};
        if (i_mem_ack && cnt_q == LAST) state_d = S_RESPOND;
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      way_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        vld_q[s]   <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_cpu_read_en || i_cpu_write_en) begin
            addr_q  <= i_cpu_addr;
            wdata_q <= i_cpu_write_data;
            wr_q    <= i_cpu_write_en;
          end
        end
        S_LOOKUP: begin
          way_q <= hit ? hit_way : vic_way;
          cnt_q <= '0;
        end
        S_WRITE_BACK: begin
          if (i_mem_ack) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) dirty_q[req_idx][way_q] <= 1'b0;
          end
        end
        S_FILL: begin
          if (i_mem_ack) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              tag_q[way_q][req_idx]   <= req_tag;
              vld_q[req_idx][way_q]   <= 1'b1;
              dirty_q[req_idx][way_q] <= 1'b0;
            end
          end
        end
        S_RESPOND: begin
          valid_q <= 1'b1;
          if (wr_q)
            dirty_q[req_idx][way_q] <= 1'b1;
          else
            rdata_q <= data_q[way_q][req_idx][req_word];
          if (NUM_WAYS > 1) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
              if (WAY_W'(w) == way_q)
                age_q[req_idx][w] <= '0;
              else if (age_q[req_idx][w] < age_q[req_idx][way_q])
                age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; validity lives in vld_q
  always_ff @(posedge i_clk) begin
    if (state_q == S_FILL && i_mem_ack)
      data_q[way_q][req_idx][cnt_q] <= i_mem_read_data;
    else if (state_q == S_RESPOND && wr_q)
      data_q[way_q][req_idx][req_word] <= wdata_q;
  end

  assign o_cpu_read_data  = rdata_q;
  assign o_cpu_data_valid = valid_q;

endmodule

// File: tb/tb_l1_cache_assoc.sv
// Directed bench for l1_cache_assoc with a word-addressed memory model.
// Table of CPU accesses plus hand sequences for stall and mid-fill reset.
module tb_l1_cache_assoc;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cpu_read_en;
  logic        i_cpu_write_en;
  logic [31:0] i_cpu_addr;
  logic [31:0] i_cpu_write_data;
  logic        o_cpu_ready;
  logic [31:0] o_cpu_read_data;
  logic        o_cpu_data_valid;
  logic        o_mem_read_en;
  logic        o_mem_write_en;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_write_data;
  logic [31:0] i_mem_read_data;
  logic        i_mem_ack;

  always #5 i_clk = ~i_clk;

  l1_cache_assoc dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_cpu_read_en    (i_cpu_read_en),
    .i_cpu_write_en   (i_cpu_write_en),
    .i_cpu_addr       (i_cpu_addr),
    .i_cpu_write_data (i_cpu_write_data),
    .o_cpu_ready      (o_cpu_ready),
    .o_cpu_read_data  (o_cpu_read_data),
    .o_cpu_data_valid (o_cpu_data_valid),
    .o_mem_read_en    (o_mem_read_en),
    .o_mem_write_en   (o_mem_write_en),
    .o_mem_addr       (o_mem_addr),
    .o_mem_write_data (o_mem_write_data),
    .i_mem_read_data  (i_mem_read_data),
    .i_mem_ack        (i_mem_ack)
  );

  logic [31:0] mem [512];
  logic        ack_en;
  logic        both_hi = 1'b0;
  logic [31:0] rd_log[$];
  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];

  assign i_mem_ack       = ack_en;
  assign i_mem_read_data = mem[o_mem_addr[10:2]];

  always @(posedge i_clk) begin
    if (o_mem_read_en && i_mem_ack) rd_log.push_back(o_mem_addr);
    if (o_mem_write_en && i_mem_ack) begin
      wa_log.push_back(o_mem_addr);
      wd_log.push_back(o_mem_write_data);
      mem[o_mem_addr[10:2]] = o_mem_write_data;
    end
    if (o_mem_read_en && o_mem_write_en) both_hi = 1'b1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_logs();
    rd_log.delete();
    wa_log.delete();
    wd_log.delete();
  endtask

  task automatic start_req(input logic wr, input logic [31:0] a,
                           input logic [31:0] d);
    @(negedge i_clk);
    for (int i = 0; i < 50 && !o_cpu_ready; i++) @(negedge i_clk);
    i_cpu_write_en   = wr;
    i_cpu_read_en    = !wr;
    i_cpu_addr       = a;
    i_cpu_write_data = d;
    @(posedge i_clk);
    #1;
    i_cpu_read_en  = 1'b0;
    i_cpu_write_en = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [31:0] rd);
    lat = 0;
    while (!o_cpu_data_valid && lat < 300) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    rd = o_cpu_read_data;
    if (lat >= 300) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no valid pulse expected one");
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          n_rd;
    int          n_wr;
    int          lat;
  } vec_t;

  vec_t vt[10];
  int          lat;
  logic [31:0] rd;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h5000_0000 | (i << 2);
    for (int k = 0; k < 4; k++) mem[64 + k] = 32'hA0 + k;

    vt[0] = '{1'b0, 32'h104, 32'h0, 32'hA1, 4, 0, 6};
    vt[1] = '{1'b0, 32'h104, 32'h0, 32'hA1, 0, 0, 2};
    vt[2] = '{1'b1, 32'h108, 32'hDEADBEEF, 32'h0, 0, 0, 2};
    vt[3] = '{1'b0, 32'h108, 32'h0, 32'hDEADBEEF, 0, 0, 2};
    vt[4] = '{1'b1, 32'h100, 32'h11111111, 32'h0, 0, 0, 2};
    vt[5] = '{1'b0, 32'h200, 32'h0, 32'h5000_0200, 4, 0, 6};
    vt[6] = '{1'b0, 32'h200, 32'h0, 32'h5000_0200, 0, 0, 2};
    vt[7] = '{1'b0, 32'h300, 32'h0, 32'h5000_0300, 4, 4, 10};
    vt[8] = '{1'b0, 32'h100, 32'h0, 32'h11111111, 4, 0, 6};
    vt[9] = '{1'b0, 32'h108, 32'h0, 32'hDEADBEEF, 0, 0, 2};

    i_rst            = 1'b1;
    i_cpu_read_en    = 1'b0;
    i_cpu_write_en   = 1'b0;
    i_cpu_addr       = '0;
    i_cpu_write_data = '0;
    ack_en           = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", {31'b0, o_cpu_ready}, 32'd1);
    chk("rst_valid", {31'b0, o_cpu_data_valid}, 32'd0);
    chk("rst_mem_rd", {31'b0, o_mem_read_en}, 32'd0);
    chk("rst_mem_wr", {31'b0, o_mem_write_en}, 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    chk("rst_rdata", o_cpu_read_data, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      clr_logs();
      start_req(vt[v].wr, vt[v].addr, vt[v].wdata);
      wait_done(lat, rd);
      chk($sformatf("v%0d_lat", v), lat, vt[v].lat);
      chk($sformatf("v%0d_nrd", v), rd_log.size(), vt[v].n_rd);
      chk($sformatf("v%0d_nwr", v), wa_log.size(), vt[v].n_wr);
      if (!vt[v].wr) chk($sformatf("v%0d_data", v), rd, vt[v].exp_rd);
      if (vt[v].n_rd > 0 && rd_log.size() > 0)
        chk($sformatf("v%0d_fill0", v), rd_log[0],
            {vt[v].addr[31:4], 4'h0});
      if (v == 7) begin
        for (int k = 0; k < 4; k++) begin
          if (k < wa_log.size()) begin
            chk($sformatf("wb_addr%0d", k), wa_log[k], 32'h100 + 4 * k);
            chk($sformatf("wb_fillord%0d", k), rd_log[k], 32'h300 + 4 * k);
          end
        end
        if (wd_log.size() == 4) begin
          chk("wb_d0", wd_log[0], 32'h11111111);
          chk("wb_d1", wd_log[1], 32'hA1);
          chk("wb_d2", wd_log[2], 32'hDEADBEEF);
          chk("wb_d3", wd_log[3], 32'hA3);
        end
      end
    end

    // Clean eviction: third miss in set 0 replaces 0x400 without write-back
    do_reset();
    clr_logs();
    start_req(1'b0, 32'h400, 32'h0);
    wait_done(lat, rd);
    start_req(1'b0, 32'h500, 32'h0);
    wait_done(lat, rd);
    clr_logs();
    start_req(1'b0, 32'h600, 32'h0);
    wait_done(lat, rd);
    chk("clean_lat", lat, 6);
    chk("clean_nwr", wa_log.size(), 0);
    chk("clean_data", rd, 32'h5000_0600);
    clr_logs();
    start_req(1'b0, 32'h500, 32'h0);
    wait_done(lat, rd);
    chk("clean_keep500", lat, 2);
    clr_logs();
    start_req(1'b0, 32'h400, 32'h0);
    wait_done(lat, rd);
    chk("clean_gone400", lat, 6);
    chk("clean_data400", rd, 32'h5000_0400);

    // Five-cycle stall before word 2 of a fill
    do_reset();
    clr_logs();
    start_req(1'b0, 32'h104, 32'h0);
    fork
      wait_done(lat, rd);
      begin
        for (int i = 0; i < 100 && rd_log.size() < 2; i++)
          @(negedge i_clk);
        ack_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
          chk($sformatf("stall_addr%0d", k), o_mem_addr, 32'h108);
          chk($sformatf("stall_rd%0d", k), {31'b0, o_mem_read_en}, 32'd1);
          @(negedge i_clk);
        end
        ack_en = 1'b1;
      end
    join
    chk("stall_lat", lat, 11);
    chk("stall_data", rd, 32'hA1);

    // Reset after two fill acks aborts the fill
    do_reset();
    clr_logs();
    start_req(1'b0, 32'h104, 32'h0);
    for (int i = 0; i < 100 && rd_log.size() < 2; i++) @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    chk("abort_rd_en", {31'b0, o_mem_read_en}, 32'd0);
    chk("abort_wr_en", {31'b0, o_mem_write_en}, 32'd0);
    chk("abort_ready", {31'b0, o_cpu_ready}, 32'd1);
    @(negedge i_clk);
    i_rst = 1'b0;
    clr_logs();
    start_req(1'b0, 32'h104, 32'h0);
    wait_done(lat, rd);
    chk("refetch_lat", lat, 6);
    chk("refetch_nrd", rd_log.size(), 4);
    for (int k = 0; k < 4 && k < rd_log.size(); k++)
      chk($sformatf("refetch_addr%0d", k), rd_log[k], 32'h100 + 4 * k);
    chk("refetch_data", rd, 32'hA1);

    chk("no_dual_strobe", {31'b0, both_hi}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/l1_cache_assoc.md
Name: l1_cache_assoc

Overview:
Parametrised N-way set-associative, write-back, write-allocate L1 data cache; successor to the direct-mapped L1 block. Sits between a single CPU load/store port and a word-serial lower-level memory port. Adds configurable associativity with true-LRU replacement, a ready/valid CPU handshake, and an acknowledged burst memory interface for line fill and dirty write-back.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width in bits; multiple of 8
LINE_WORDS, 4, words per line; power of 2, >=2
NUM_SETS, 16, sets; power of 2
NUM_WAYS, 2, associativity; power of 2, >=1

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  reset, synchronous, active-high
i_cpu_read_en  in  1  read request; sampled only when o_cpu_ready=1
i_cpu_write_en  in  1  write request; wins if both asserted
i_cpu_addr  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored
i_cpu_write_data  in  DATA_WIDTH  store data
o_cpu_ready  out  1  cache idle, can accept a request
o_cpu_read_data  out  DATA_WIDTH  load data, valid with o_cpu_data_valid
o_cpu_data_valid  out  1  one-cycle completion pulse (reads and writes)
o_mem_read_en  out  1  fill word request
o_mem_write_en  out  1  write-back word request
o_mem_addr  out  ADDR_WIDTH  word-aligned memory address
o_mem_write_data  out  DATA_WIDTH  write-back word
i_mem_read_data  in  DATA_WIDTH  fill word, valid when i_mem_ack and o_mem_read_en
i_mem_ack  in  1  memory accepts/returns the current word this cycle

Behaviour:
- Address split: offset = log2(LINE_WORDS*DATA_WIDTH/8) LSBs, index = next log2(NUM_SETS) bits, tag = remainder.
- Per way/set: tag, valid, dirty, LINE_WORDS data words. Per set: LRU age of log2(NUM_WAYS) bits per way (0 = MRU).
- Reset: all valid, dirty and LRU ages cleared; state IDLE; o_cpu_ready=1; all other outputs 0. Reset mid-operation aborts immediately: no further memory strobes after the reset cycle, and the partially filled line stays invalid.
- FSM states: IDLE, LOOKUP, WRITE_BACK, FILL, RESPOND.
- IDLE: o_cpu_ready=1. On read_en|write_en, register addr, data and op; go to LOOKUP. o_cpu_ready=0 in every other state.
- LOOKUP: compare tag across all ways of the set. Hit -> go to RESPOND. Miss -> choose victim: lowest-index invalid way, else the way with maximum age. Victim valid and dirty -> WRITE_BACK, else FILL.
- Hit latency: request sampled at edge T, o_cpu_data_valid high for the cycle after edge T+2, read data valid with it. Next request accepted the cycle after.
- WRITE_BACK: word counter 0..LINE_WORDS-1. o_mem_write_en=1, o_mem_addr = {victim tag, index, counter, 0s}, o_mem_write_data = victim word. Counter advances only on i_mem_ack. Ack on last word -> clear dirty, go to FILL.
- FILL: o_mem_read_en=1, o_mem_addr = {req tag, index, counter, 0s}. Each i_mem_ack writes i_mem_read_data into the victim way at counter. Ack on last word -> set tag, valid=1, dirty=0, go to RESPOND. Addresses strictly ascending from word 0.
- Memory stall: ack low -> address, data and strobe held unchanged, indefinitely; no timeout.
- RESPOND: read -> drive addressed word. Write -> update addressed word and set dirty. Both pulse o_cpu_data_valid and return to IDLE. o_cpu_read_data is held until the next read completion; for writes it is don't-care.
- LRU update in RESPOND: accessed way age -> 0; ways with age less than its old age are incremented; others unchanged. With NUM_WAYS=1 there is no LRU state.
- Requests asserted while o_cpu_ready=0 are ignored; the CPU must hold or re-issue them.
- o_mem_read_en and o_mem_write_en are never both high.

Test Plan:
- Cold read 0x0000_0104 -> FILL reads 0x100,0x104,0x108,0x10C; mem returns 0xA0..0xA3 -> o_cpu_read_data=0xA1 with one valid pulse. Re-read 0x104 -> valid 2 cycles after acceptance, no mem strobes.
- Write 0xDEADBEEF to 0x108 (hit) then read 0x108 -> 0xDEADBEEF, no o_mem_write_en.
- Set 0: write 0x100 (dirty), read 0x200, read 0x200, read 0x300 -> victim is the 0x100 way; WRITE_BACK to 0x100..0x10C with 0x108 word = 0xDEADBEEF, then FILL 0x300..0x30C.
- Clean eviction: read 0x400, 0x500, 0x600 in set 0 from reset -> third miss goes straight to FILL evicting 0x400; zero write strobes.
- Stall: hold i_mem_ack low 5 cycles before word 2 of a fill -> o_mem_addr stays 0x108 and read_en stays high; completion delayed exactly 5 cycles.
- Assert i_rst after 2 fill acks -> next cycle all strobes 0, o_cpu_ready=1; read of the same address misses and refetches all 4 words.
